// File: rtl/led_pkg.sv
// Shared types and constants for the LED strip path (sequencer, latch timer,
// serialiser and top level).
package led_pkg;

    localparam int LED_COLOR_W         = 24;
    localparam int LATCH_CYCLES_100MHZ = 8000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_PIX,
        SEND,
        WAIT_DRV,
        LATCH
    } seq_state_t;

    // Index width for a strip of n LEDs; a single-LED strip still needs one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_latch_timer.sv
// Loadable down-counter: after a load of V it reports done on the (V+1)-th
// cycle, and flags one cycle ahead when that final cycle is coming.
module led_latch_timer #(
    parameter int CNT_W = 13
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] load_val_in,
    output logic             done_out,
    output logic             expire_next_out
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (load_in) begin
            count_d  = load_val_in;
            active_d = 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    assign done_out = active_q && (count_q == '0);

    // Lets the owner register a pulse that lines up with the final cycle.
    assign expire_next_out = load_in ? (load_val_in == '0)
                                     : (active_q && (count_q == CNT_W'(1)));

endmodule

// File: rtl/led_strip_sequencer.sv
// Frame sequencer for a WS2812-style strip: fetches one GRB word per LED,
// hands it to the single-word serialiser, then holds the latch gap.
module led_strip_sequencer
    import led_pkg::*;
#(
    parameter int  NUM_LED      = 10,
    parameter int  COLOR_W      = LED_COLOR_W,
    parameter int  LATCH_CYCLES = LATCH_CYCLES_100MHZ,
    parameter int  FRAME_CNT_W  = 16,
    localparam int AW           = addr_width(NUM_LED)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   continuous_in,
    output logic [AW-1:0]          pix_addr_out,
    output logic                   pix_req_out,
    input  logic [COLOR_W-1:0]     pix_data_in,
    input  logic                   pix_valid_in,
    output logic [COLOR_W-1:0]     drv_data_out,
    output logic                   drv_valid_out,
    input  logic                   drv_finished_in,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [FRAME_CNT_W-1:0] frame_count_out
);

    localparam int          LATCH_W    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [LATCH_W-1:0] LATCH_LOAD = LATCH_W'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0]      LAST_IDX   = AW'(NUM_LED - 1);

    seq_state_t             state_q, state_d;
    logic [AW-1:0]          index_q, index_d;
    logic [COLOR_W-1:0]     drv_data_q, drv_data_d;
    logic                   pix_req_q, pix_req_d;
    logic                   drv_valid_q, drv_valid_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic latch_load;
    logic latch_done;
    logic latch_expire_next;

    led_latch_timer #(
        .CNT_W (LATCH_W)
    ) u_latch_timer (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .load_in         (latch_load),
        .load_val_in     (LATCH_LOAD),
        .done_out        (latch_done),
        .expire_next_out (latch_expire_next)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        drv_data_d    = drv_data_q;
        frame_count_d = frame_count_q;
        latch_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in || continuous_in) begin
                    state_d = FETCH;
                    index_d = '0;
                end
            end
            FETCH: begin
                state_d = WAIT_PIX;
            end
            WAIT_PIX: begin
                if (pix_valid_in) begin
                    drv_data_d = pix_data_in;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_DRV;
            end
            WAIT_DRV: begin
                if (drv_finished_in) begin
                    if (index_q == LAST_IDX) begin
                        state_d    = LATCH;
                        latch_load = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                if (latch_done) begin
                    if (continuous_in) begin
                        state_d = FETCH;
                        index_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight
        // off a flop; frame_done therefore lands on the final latch cycle.
        frame_done_d = (state_d == LATCH) && latch_expire_next;
        if (frame_done_d) begin
            frame_count_d = frame_count_q + 1'b1;
        end
        pix_req_d   = (state_d == FETCH);
        drv_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            index_q       <= '0;
            drv_data_q    <= '0;
            pix_req_q     <= 1'b0;
            drv_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            drv_data_q    <= drv_data_d;
            pix_req_q     <= pix_req_d;
            drv_valid_q   <= drv_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_addr_out    = index_q;
    assign pix_req_out     = pix_req_q;
    assign drv_data_out    = drv_data_q;
    assign drv_valid_out   = drv_valid_q;
    assign busy_out        = busy_q;
    assign frame_done_out  = frame_done_q;
    assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Scoreboard bench for led_strip_sequencer: two strip configurations, random
// pixel/driver latencies, reference frames computed from the pixel memory.
module tb_led_strip_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %s", name, what);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_blk
        localparam int NL      = (gi == 0) ? 3 : 1;
        localparam int LAT     = (gi == 0) ? 20 : 6;
        localparam int FW      = (gi == 0) ? 16 : 2;
        localparam int AW      = (NL > 1) ? $clog2(NL) : 1;
        localparam int NCONT   = (gi == 0) ? 3 : 5;
        localparam int RST_IDX = (NL > 1) ? 1 : 0;

        logic          rst = 1'b1;
        logic          start = 1'b0;
        logic          cont = 1'b0;
        logic          pix_req, pix_valid, drv_valid, drv_fin, busy, frame_done;
        logic [AW-1:0] pix_addr;
        logic [23:0]   pix_data, drv_data;
        logic [FW-1:0] frame_count;

        led_strip_sequencer #(
            .NUM_LED      (NL),
            .COLOR_W      (24),
            .LATCH_CYCLES (LAT),
            .FRAME_CNT_W  (FW)
        ) u_dut (
            .clk_in          (clk),
            .rst_in          (rst),
            .start_in        (start),
            .continuous_in   (cont),
            .pix_addr_out    (pix_addr),
            .pix_req_out     (pix_req),
            .pix_data_in     (pix_data),
            .pix_valid_in    (pix_valid),
            .drv_data_out    (drv_data),
            .drv_valid_out   (drv_valid),
            .drv_finished_in (drv_fin),
            .busy_out        (busy),
            .frame_done_out  (frame_done),
            .frame_count_out (frame_count)
        );

        logic [23:0] pix_mem [NL];
        int          exp_addr[$];
        logic [23:0] exp_data[$];
        int          exp_cnt[$];
        int          model_cnt = 0;
        int          last_fin = 0;
        bit          drv_busy = 1'b0;
        bit          fin = 1'b0;

        // Pixel source: answers each request after 1..3 cycles; while the
        // driver is busy it also throws junk words that must be ignored.
        initial begin : p_pix
            int due;
            int paddr;
            bit have;
            have = 1'b0; due = 0; paddr = 0;
            pix_valid = 1'b0;
            pix_data  = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    have = 1'b0;
                end else if (pix_req) begin
                    have  = 1'b1;
                    paddr = int'(pix_addr);
                    due   = cyc + int'($urandom_range(1, 3));
                end
                @(posedge clk); #1;
                pix_valid = 1'b0;
                pix_data  = '0;
                if (have && cyc == due) begin
                    pix_valid = 1'b1;
                    pix_data  = pix_mem[paddr];
                    have      = 1'b0;
                end else if (drv_busy && $urandom_range(3) == 0) begin
                    pix_valid = 1'b1;
                    pix_data  = {16'hDEAD, 8'($urandom_range(255))};
                end
            end
        end

        // Serialiser stand-in: finished pulses 3..10 cycles after the start pulse.
        initial begin : p_drv
            int ddue;
            bit dpend;
            dpend = 1'b0; ddue = 0;
            drv_fin = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    dpend    = 1'b0;
                    drv_busy = 1'b0;
                end else if (drv_valid) begin
                    dpend    = 1'b1;
                    drv_busy = 1'b1;
                    ddue     = cyc + int'($urandom_range(3, 10));
                end
                @(posedge clk); #1;
                drv_fin = 1'b0;
                if (dpend && cyc == ddue) begin
                    drv_fin  = 1'b1;
                    dpend    = 1'b0;
                    drv_busy = 1'b0;
                    last_fin = cyc;
                end
            end
        end

        initial begin : p_mon
            forever begin
                @(negedge clk);
                if (!rst && pix_req) begin
                    if (exp_addr.size() == 0)
                        fail_now($sformatf("b%0d_pix_req", gi), "unexpected fetch strobe, required none");
                    else
                        check($sformatf("b%0d_req_addr", gi), 64'(pix_addr), 64'(exp_addr[0]));
                end
                if (!rst && drv_valid) begin
                    if (exp_data.size() == 0) begin
                        fail_now($sformatf("b%0d_drv_valid", gi), "unexpected driver start, required none");
                    end else begin
                        check($sformatf("b%0d_drv_addr", gi), 64'(pix_addr), 64'(exp_addr.pop_front()));
                        check($sformatf("b%0d_drv_data", gi), 64'(drv_data), 64'(exp_data.pop_front()));
                    end
                end
                if (!rst && frame_done) begin
                    if (exp_cnt.size() == 0) begin
                        fail_now($sformatf("b%0d_frame_done", gi), "unexpected frame_done, required none");
                    end else begin
                        check($sformatf("b%0d_frame_count", gi), 64'(frame_count), 64'(exp_cnt.pop_front()));
                        check($sformatf("b%0d_latch_gap", gi), 64'(cyc - last_fin), 64'(LAT));
                        check($sformatf("b%0d_busy_at_done", gi), 64'(busy), 64'd1);
                    end
                end
            end
        end

        task automatic rand_mem();
            for (int i = 0; i < NL; i++) pix_mem[i] = 24'($urandom);
        endtask

        task automatic push_frames(input int nf);
            for (int f = 0; f < nf; f++) begin
                for (int i = 0; i < NL; i++) begin
                    exp_addr.push_back(i);
                    exp_data.push_back(pix_mem[i]);
                end
                model_cnt = (model_cnt + 1) % (1 << FW);
                exp_cnt.push_back(model_cnt);
            end
        endtask

        task automatic wait_frames(input int nf, output int gaps);
            int seen;
            int budget;
            seen = 0;
            budget = 3000 * nf;
            gaps = 0;
            while (seen < nf && budget > 0) begin
                @(negedge clk);
                budget--;
                if (!busy) gaps++;
                if (frame_done) seen++;
            end
            if (seen < nf)
                fail_now($sformatf("b%0d_frame_timeout", gi), "no frame_done within budget, required one");
        endtask

        task automatic pulse_start();
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        endtask

        task automatic do_reset(input int ncyc);
            @(posedge clk); #1;
            rst = 1'b1;
            exp_addr.delete();
            exp_data.delete();
            exp_cnt.delete();
            model_cnt = 0;
            repeat (ncyc) @(posedge clk);
            #1;
            rst = 1'b0;
        endtask

        task automatic check_reset_outputs(input string tag);
            @(negedge clk);
            check($sformatf("b%0d_%s_pix_addr", gi, tag), 64'(pix_addr), 64'd0);
            check($sformatf("b%0d_%s_pix_req", gi, tag), 64'(pix_req), 64'd0);
            check($sformatf("b%0d_%s_drv_data", gi, tag), 64'(drv_data), 64'd0);
            check($sformatf("b%0d_%s_drv_valid", gi, tag), 64'(drv_valid), 64'd0);
            check($sformatf("b%0d_%s_busy", gi, tag), 64'(busy), 64'd0);
            check($sformatf("b%0d_%s_frame_done", gi, tag), 64'(frame_done), 64'd0);
            check($sformatf("b%0d_%s_frame_count", gi, tag), 64'(frame_count), 64'd0);
        endtask

        task automatic check_idle_after(input string tag);
            @(negedge clk);
            check($sformatf("b%0d_%s_busy_after", gi, tag), 64'(busy), 64'd0);
            check($sformatf("b%0d_%s_count_after", gi, tag), 64'(frame_count), 64'(model_cnt));
        endtask

        task automatic run_oneshot(input string tag);
            int g;
            push_frames(1);
            pulse_start();
            wait_frames(1, g);
            check_idle_after(tag);
        endtask

        task automatic run_cont(input int nf, input string tag);
            int g1;
            int g2;
            push_frames(nf);
            @(posedge clk); #1;
            cont = 1'b1;
            @(posedge clk); #1;
            wait_frames(nf - 1, g1);
            @(posedge clk); #1;
            cont = 1'b0;
            wait_frames(1, g2);
            check($sformatf("b%0d_%s_idle_gaps", gi, tag), 64'(g1 + g2), 64'd0);
            check_idle_after(tag);
        endtask

        initial begin : p_stim
            int  budget;
            bit  hit;
            for (int i = 0; i < NL; i++) pix_mem[i] = {8'hA0, 8'(i), 8'h0F};
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            check_reset_outputs("por");

            run_oneshot("oneshot");

            do_reset(2);
            check_reset_outputs("rst2");
            rand_mem();
            run_cont(NCONT, "cont");

            // start pulses while a frame is in flight must not add a frame
            rand_mem();
            push_frames(1);
            pulse_start();
            hit = 1'b0;
            budget = 3000;
            while (!hit && budget > 0) begin
                @(negedge clk);
                budget--;
                if (frame_done) begin
                    hit = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    start = ($urandom_range(3) == 0);
                end
            end
            if (!hit) fail_now($sformatf("b%0d_drop_timeout", gi), "no frame_done within budget, required one");
            @(posedge clk); #1;
            start = 1'b0;
            repeat (40) @(negedge clk);
            check($sformatf("b%0d_drop_busy", gi), 64'(busy), 64'd0);
            check($sformatf("b%0d_drop_count", gi), 64'(frame_count), 64'(model_cnt));
            check($sformatf("b%0d_drop_leftover", gi), 64'(exp_data.size()), 64'd0);

            // reset while the driver is serialising LED RST_IDX
            rand_mem();
            push_frames(1);
            pulse_start();
            hit = 1'b0;
            budget = 2000;
            while (!hit && budget > 0) begin
                @(negedge clk);
                budget--;
                if (drv_valid && int'(pix_addr) == RST_IDX) hit = 1'b1;
            end
            if (!hit) fail_now($sformatf("b%0d_rst_point", gi), "never reached target LED, required it");
            do_reset(1);
            check_reset_outputs("midframe");
            run_oneshot("after_rst");

            for (int r = 0; r < 6; r++) begin
                int nf;
                rand_mem();
                nf = int'($urandom_range(1, 3));
                if (nf == 1) run_oneshot($sformatf("rand%0d", r));
                else         run_cont(nf, $sformatf("rand%0d", r));
            end

            repeat (5) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin : p_end
        int budget;
        budget = 90000;
        while (!(g_blk[0].fin && g_blk[1].fin) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) fail_now("global_timeout", "stimulus unfinished, required finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_strip_sequencer.md
Name: led_strip_sequencer

Overview:
- Frame-level controller for a WS2812-style LED strip.
- On each frame it walks LED indices 0..NUM_LED-1 and fetches a 24-bit GRB word per LED from an external pixel source (frame buffer or pattern generator).
- It hands each word to the existing single-word serialiser (led_driver) with a valid/finished handshake, then holds the line idle for the latch gap.
- Supports one-shot and continuous (free-running) refresh. Replaces the fixed test-pattern loop at top level.

Parameters:
- NUM_LED, 10, number of LEDs on the strip (1..4096).
- COLOR_W, 24, bits per LED word passed to the driver.
- LATCH_CYCLES, 8000, idle clock cycles after the last LED before the frame is complete (80 us at 100 MHz).
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  1-cycle request to send one frame; ignored unless idle.
- continuous_in  input  1  level; when high, a new frame starts automatically after each latch gap.
- pix_addr_out  output  AW=max(1,$clog2(NUM_LED))  LED index being fetched.
- pix_req_out  output  1  1-cycle fetch strobe for pix_addr_out.
- pix_data_in  input  COLOR_W  pixel word.
- pix_valid_in  input  1  pix_data_in valid. Arbitrary latency ≥1 cycle after pix_req_out.
- drv_data_out  output  COLOR_W  word to led_driver rgb_in; held stable until the driver finishes.
- drv_valid_out  output  1  1-cycle start pulse to the led_driver valid_in.
- drv_finished_in  input  1  led_driver finished_led.
- busy_out  output  1  high from frame start through the end of the latch gap.
- frame_done_out  output  1  1-cycle pulse when the latch gap completes.
- frame_count_out  output  FRAME_CNT_W  completed frames. Wraps at 2^FRAME_CNT_W.

Behaviour:
- Reset: state IDLE.
  - pix_addr_out=0, pix_req_out=0, drv_data_out=0, drv_valid_out=0.
  - busy_out=0, frame_done_out=0, frame_count_out=0.
  - Internal LED index and latch counter cleared.
- Reset mid-frame aborts immediately with the same values and performs no latch gap. The driver sees the same rst_in.
- All outputs are registered.
- States (enum in package): IDLE, FETCH, WAIT_PIX, SEND, WAIT_DRV, LATCH.
- IDLE → FETCH when start_in=1 or continuous_in=1. Index=0, busy_out rises the next cycle.
- FETCH: pix_req_out=1 for exactly one cycle with pix_addr_out=index → WAIT_PIX.
- WAIT_PIX: on pix_valid_in, capture pix_data_in into drv_data_out → SEND. pix_valid_in outside WAIT_PIX is ignored.
- SEND: drv_valid_out=1 for one cycle → WAIT_DRV.
- WAIT_DRV: on drv_finished_in:
  - if index==NUM_LED-1 → LATCH with counter=0;
  - else index+1 → FETCH.
- drv_finished_in arriving in the same cycle as drv_valid_out is not legal driver behaviour and is ignored (it is only sampled in WAIT_DRV).
- LATCH: count to LATCH_CYCLES-1. On the final cycle:
  - frame_done_out=1 and frame_count_out+1;
  - if continuous_in=1 → FETCH (index=0, busy_out stays 1);
  - else → IDLE (busy_out falls the next cycle).
- start_in during any non-IDLE state is dropped. Requests are not queued.
- Deasserting continuous_in mid-frame finishes the current frame, then goes to IDLE.
- NUM_LED=1 edge case: first index is also last; the path is FETCH→WAIT_PIX→SEND→WAIT_DRV→LATCH.
- Index comparison uses AW bits. No wrap of the index is possible.
- Minimum per-LED overhead outside driver time is 3 cycles + pixel latency.

Decomposition:
- Package led_pkg holds:
  - the seq_state_t enum;
  - localparams LED_COLOR_W=24 and LATCH_CYCLES_100MHZ=8000, shared with led_driver and top level.
- Natural sub-module: led_latch_timer, a down-counter with load/done used for the LATCH gap. It is reusable by led_driver for its own reset timing.
- led_driver is instantiated at top level, not inside this block.

Test Plan:
- NUM_LED=3, LATCH_CYCLES=20, pixel source returns {8'hA0,idx,8'h0F} at 2-cycle latency, driver model finishes 30 cycles after valid; pulse start_in.
  - Expected: pix_addr_out sequence 0,1,2; drv_data_out 24'hA0000F, A0010F, A0020F, each with a single drv_valid_out.
  - Expected: frame_done_out exactly 20 cycles after the third finished; frame_count_out=1; busy_out=0 one cycle later.
- continuous_in=1 for 3 frames, then 0.
  - Expected: no IDLE gap between frames; frame_count_out=3; busy_out falls after the third frame_done_out.
- start_in pulsed while in WAIT_DRV and LATCH.
  - Expected: no extra frame; frame_count_out increments by 1 only.
- rst_in asserted during WAIT_DRV of LED 1.
  - Expected: next cycle all outputs at reset values; frame_count_out=0; a subsequent start_in sends a full frame from index 0.
- NUM_LED=1, pix latency 1, driver latency 5.
  - Expected: exactly one drv_valid_out, then LATCH; frame_done_out asserted once.
- FRAME_CNT_W=2, continuous for 5 frames.
  - Expected: frame_count_out sequence 1,2,3,0,1.
